spi_slave_ctrl: RTL and testbench

SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

---
 rtl/spi_ctrl_pkg.sv | 28 ++
 rtl/spi_tx_shifter.sv | 45 ++++
 rtl/spi_slave_ctrl.sv | 141 ++++++++++++++
 tb/tb_spi_slave_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared types and defaults for the SPI slave controller: FSM states,
// command codes carried in the top two frame bits, and width defaults.
package spi_ctrl_pkg;

   localparam int FRAME_BITS_DEF = 10;
   localparam int DATA_BITS_DEF  = 8;

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA
   } state_t;

   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_t;

   // The command field sits in the two MSBs of a received frame.
   function automatic cmd_t frame_cmd(input logic [FRAME_BITS_DEF-1:0] frame);
      return cmd_t'(frame[FRAME_BITS_DEF-1 -: 2]);
   endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// MISO serialiser: loads a RAM read word and presents it MSB first, one bit
// per enabled cycle; output is forced low whenever no word is in flight.
module spi_tx_shifter
   import spi_ctrl_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 load,
   input  logic [DATA_BITS-1:0] data,
   input  logic                 shift_en,
   output logic                 sout,
   output logic                 busy,
   output logic                 done
);

   localparam int CW = $clog2(DATA_BITS + 1);

   logic [DATA_BITS-1:0] sh_reg;
   logic [CW-1:0]        cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_reg <= '0;
         cnt    <= '0;
      end else if (clr) begin
         sh_reg <= '0;
         cnt    <= '0;
      end else if (load) begin
         sh_reg <= data;
         cnt    <= CW'(DATA_BITS);
      end else if (shift_en && cnt != '0) begin
         sh_reg <= sh_reg << 1;
         cnt    <= cnt - 1'b1;
      end
   end

   assign busy = (cnt != '0);
   assign sout = busy & sh_reg[DATA_BITS-1];
   // Terminal count: the edge that shifts out the last bit.
   assign done = shift_en && !clr && !load && (cnt == CW'(1));

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave frame controller: decodes R/W, deserialises MOSI frames to the
// RAM and serialises RAM read data on MISO. Optional SPI_CTRL_FRAME_ERR_EN adds frame_err.
//
// state     | meaning
// IDLE      | SS_n high, waiting for a frame
// CHK_CMD   | sampling the R/W bit
// WRITE     | shifting a write frame (address or data)
// READ_ADD  | shifting a read-address frame
// READ_DATA | shifting a read-data frame, then waiting for / sending RAM data
module spi_slave_ctrl
   import spi_ctrl_pkg::*;
#(
   parameter int FRAME_BITS = FRAME_BITS_DEF,
   parameter int DATA_BITS  = DATA_BITS_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  SS_n,
   input  logic                  MOSI,
   output logic                  MISO,
   output logic [FRAME_BITS-1:0] rx_data,
   output logic                  rx_valid,
   input  logic [DATA_BITS-1:0]  tx_data,
   input  logic                  tx_valid
`ifdef SPI_CTRL_FRAME_ERR_EN
   ,
   output logic                  frame_err
`endif
);

   localparam int RCW = $clog2(FRAME_BITS + 1);

   state_t          state, state_nxt;
   logic [RCW-1:0]  rx_cnt;
   logic            rd_addr_seen;
   logic            tx_finished;
   logic            shifting;
   logic            last_bit;
   logic            tx_load;
   logic            tx_shift_en;
   logic            tx_busy;
   logic            tx_done;

   always_comb begin
      state_nxt   = state;
      shifting    = 1'b0;
      last_bit    = 1'b0;
      tx_load     = 1'b0;
      tx_shift_en = 1'b0;

      if (!SS_n && rx_cnt != '0 &&
          (state == WRITE || state == READ_ADD || state == READ_DATA)) begin
         shifting = 1'b1;
         last_bit = (rx_cnt == RCW'(1));
      end

      // Wait phase: frame fully received, nothing sent yet for this frame.
      if (!SS_n && state == READ_DATA && rx_cnt == '0 && !tx_busy && !tx_finished)
         tx_load = tx_valid;

      tx_shift_en = !SS_n && (state == READ_DATA);

      case (state)
         IDLE:    if (!SS_n) state_nxt = CHK_CMD;
         CHK_CMD: begin
            if (!MOSI)
               state_nxt = WRITE;
            else if (rd_addr_seen)
               state_nxt = READ_DATA;
            else
               state_nxt = READ_ADD;
         end
         default: state_nxt = state;
      endcase

      if (SS_n)
         state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         rx_cnt       <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rd_addr_seen <= 1'b0;
         tx_finished  <= 1'b0;
      end else begin
         state    <= state_nxt;
         rx_valid <= last_bit;

         // Down-counter of frame bits still to receive; zero ignores extras.
         if (SS_n)
            rx_cnt <= '0;
         else if (state == CHK_CMD)
            rx_cnt <= RCW'(FRAME_BITS);
         else if (shifting)
            rx_cnt <= rx_cnt - 1'b1;

         if (shifting)
            rx_data <= {rx_data[FRAME_BITS-2:0], MOSI};

         if (last_bit && state == READ_ADD)
            rd_addr_seen <= 1'b1;
         else if (tx_done)
            rd_addr_seen <= 1'b0;

         if (SS_n)
            tx_finished <= 1'b0;
         else if (tx_done)
            tx_finished <= 1'b1;
      end
   end

   spi_tx_shifter #(
      .DATA_BITS (DATA_BITS)
   ) u_tx_shifter (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (SS_n),
      .load     (tx_load),
      .data     (tx_data),
      .shift_en (tx_shift_en),
      .sout     (MISO),
      .busy     (tx_busy),
      .done     (tx_done)
   );

`ifdef SPI_CTRL_FRAME_ERR_EN
   // Abort after the R/W bit: frame incomplete, or read data not fully sent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         frame_err <= 1'b0;
      else
         frame_err <= SS_n &&
            (((state == WRITE || state == READ_ADD || state == READ_DATA) && rx_cnt != '0) ||
             (state == READ_DATA && !tx_finished));
   end
`endif

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Randomised bench for spi_slave_ctrl; expectations come from a frame-level
// model working in cycle indices relative to the SS_n falling edge.
module tb_spi_slave_ctrl;

   localparam int FB = 10;
   localparam int DB = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ss_n;
   logic          mosi;
   logic          miso;
   logic [FB-1:0] rx_data;
   logic          rx_valid;
   logic [DB-1:0] tx_data;
   logic          tx_valid;
`ifdef SPI_CTRL_FRAME_ERR_EN
   logic          frame_err;
`endif

   int n_chk = 0;
   int n_err = 0;
   bit seen  = 1'b0;

   always #5 clk = ~clk;

   spi_slave_ctrl #(.FRAME_BITS(FB), .DATA_BITS(DB)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SS_n     (ss_n),
      .MOSI     (mosi),
      .MISO     (miso),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid)
`ifdef SPI_CTRL_FRAME_ERR_EN
      ,
      .frame_err(frame_err)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Posedge 0 is the first with SS_n low, posedge 1 samples R/W, posedges
   // 2..FB+1 sample the frame; posedge n_low is the SS_n rising edge.
   // d > 0: tx_valid offered at posedge FB+1+d of a read-data frame.
   task automatic do_frame(input bit rw, input logic [FB-1:0] frame, input int n_low,
                           input int d, input logic [DB-1:0] byte_v, input int rst_at);
      bit   is_rd, complete, loaded, tx_cmp;
      int   l;
      logic exp_miso;
      is_rd    = rw && seen;
      complete = (n_low >= 2 + FB);
      l        = 1 + FB + d;
      loaded   = is_rd && complete && d > 0 && l <= n_low - 1;
      tx_cmp   = loaded && (l + DB <= n_low - 1);
      for (int p = 0; p <= n_low; p++) begin
         @(negedge clk);
         ss_n = (p == n_low);
         if (p == 1)
            mosi = rw;
         else if (p >= 2 && p - 2 < FB)
            mosi = frame[FB - 1 - (p - 2)];
         else
            mosi = ($urandom_range(0, 1) != 0);
         tx_data = DB'($urandom);
         if (is_rd)
            tx_valid = (d > 0 && p == l) ||
                       ((p <= 1 + FB || (d > 0 && p > l)) && $urandom_range(0, 3) == 0);
         else
            tx_valid = ($urandom_range(0, 3) == 0);
         if (is_rd && d > 0 && p == l)
            tx_data = byte_v;
         @(posedge clk);
         #1;
         chk("rx_valid", rx_valid, (p == 1 + FB) && (p < n_low));
         exp_miso = 1'b0;
         if (loaded && p >= l && p <= l + DB - 1 && p < n_low)
            exp_miso = byte_v[DB - 1 - (p - l)];
         chk("miso", miso, exp_miso);
         if (complete && (p == 1 + FB || p == n_low))
            chk("rx_data", rx_data, frame);
`ifdef SPI_CTRL_FRAME_ERR_EN
         chk("frame_err", frame_err,
             (p == n_low) && (n_low >= 2) && (!complete || (is_rd && !tx_cmp)));
`endif
         if (p == rst_at) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_miso", miso, 1'b0);
            chk("rst_rx_valid", rx_valid, 1'b0);
            chk("rst_rx_data", rx_data, '0);
            @(negedge clk);
            ss_n     = 1'b1;
            tx_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            seen  = 1'b0;
            return;
         end
      end
      if (rw && !seen && complete)
         seen = 1'b1;
      else if (tx_cmp)
         seen = 1'b0;
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
         @(negedge clk);
         ss_n     = 1'b1;
         mosi     = ($urandom_range(0, 1) != 0);
         tx_valid = ($urandom_range(0, 1) != 0);
         tx_data  = DB'($urandom);
         @(posedge clk);
         #1;
         chk("gap_rx_valid", rx_valid, 1'b0);
         chk("gap_miso", miso, 1'b0);
`ifdef SPI_CTRL_FRAME_ERR_EN
         chk("gap_frame_err", frame_err, 1'b0);
`endif
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int            rw, d, n_low;
      logic [FB-1:0] fr;
      rst_n    = 1'b0;
      ss_n     = 1'b1;
      mosi     = 1'b0;
      tx_valid = 1'b0;
      tx_data  = '0;
      #12;
      chk("reset_miso", miso, 1'b0);
      chk("reset_rx_valid", rx_valid, 1'b0);
      chk("reset_rx_data", rx_data, '0);
`ifdef SPI_CTRL_FRAME_ERR_EN
      chk("reset_frame_err", frame_err, 1'b0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_frame(1'b0, 10'h0A5, 2 + FB + 2, 0, 8'h00, -1);                 // write
      do_frame(1'b1, 10'b10_0000_0011, 2 + FB + 1, 0, 8'h00, -1);        // read address
      do_frame(1'b1, 10'b11_0000_0000, 1 + FB + 1 + DB + 3, 1, 8'hC3, -1);
      do_frame(1'b1, 10'h2AA, 1 + FB + 1 + DB + 3, 1, 8'h5A, -1);        // decoded as READ_ADD
      do_frame(1'b0, 10'h155, 7, 0, 8'h00, -1);                          // abort after 5 bits
      do_frame(1'b1, 10'h300, 7, 1, 8'h81, -1);                          // aborted read data
      do_frame(1'b0, 10'h3C5, 2 + 14, 0, 8'h00, -1);                     // overlong
      do_frame(1'b1, 10'h300, 1 + FB + 20 + DB + 2, 20, 8'hA6, -1);      // delayed RAM
      do_frame(1'b1, 10'h201, 2 + FB + 1, 0, 8'h00, -1);
      do_frame(1'b1, 10'h300, 1 + FB + 1 + DB + 3, 1, 8'hFF, 1 + FB + 1 + 2);
      do_frame(1'b1, 10'h300, 1 + FB + 1 + DB + 3, 1, 8'hC3, -1);        // READ_ADD after reset

      for (int k = 0; k < 40; k++) begin
         rw = int'($urandom_range(0, 1));
         fr = FB'($urandom);
         d  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 25));
         case ($urandom_range(0, 4))
            0:       n_low = int'($urandom_range(1, 1 + FB));
            1:       n_low = 2 + FB + int'($urandom_range(0, 5));
            2:       n_low = 1 + FB + d + int'($urandom_range(1, DB));
            default: n_low = 1 + FB + d + DB + int'($urandom_range(0, 3));
         endcase
         do_frame(rw != 0, fr, n_low, d, DB'($urandom), -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
